// File: rtl/demux3_pkg.sv
// Shared constants for the 1-to-3 stream demultiplexer:
// select encodings, slot state encoding and the select decoder.
package demux3_pkg;

    localparam logic [1:0] SEL_CH1 = 2'b00;
    localparam logic [1:0] SEL_CH2 = 2'b01;
    localparam logic [1:0] SEL_CH3 = 2'b1x;

    localparam int NCH   = 3;
    localparam int CNT_W = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_st_e;

    // One-hot target: bit k-1 selects channel k; s0 is ignored when s1=1.
    function automatic logic [NCH-1:0] sel_decode(
        input logic s1,
        input logic s0
    );
        logic [1:0] sel;
        logic [NCH-1:0] tgt;
        sel = {s1, s0};
        tgt = '0;
        unique case (1'b1)
            (sel ==? SEL_CH3): tgt = 3'b100;
            (sel ==  SEL_CH2): tgt = 3'b010;
            (sel ==  SEL_CH1): tgt = 3'b001;
            default:           tgt = 3'b001;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/demux3_stream_if.sv
// Upstream and per-channel downstream handshake bundle
// of the 1-to-3 stream demultiplexer.
interface demux3_stream_if #(
    parameter int W = 8
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         s0;
    logic         s1;

    logic [2:0]   out_valid;
    logic [2:0]   out_ready;
    logic [W-1:0] out1_data;
    logic [W-1:0] out2_data;
    logic [W-1:0] out3_data;
    logic [7:0]   out1_cnt;
    logic [7:0]   out2_cnt;
    logic [7:0]   out3_cnt;

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output s0,
        output s1,
        input  out_valid,
        output out_ready,
        input  out1_data,
        input  out2_data,
        input  out3_data,
        input  out1_cnt,
        input  out2_cnt,
        input  out3_cnt
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  s0,
        input  s1,
        output out_valid,
        input  out_ready,
        output out1_data,
        output out2_data,
        output out3_data,
        output out1_cnt,
        output out2_cnt,
        output out3_cnt
    );

endinterface

// File: rtl/demux_slot.sv
// One-entry output buffer: EMPTY/FULL state, data register
// and a wrapping count of words delivered downstream.
module demux_slot
    import demux3_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     load_data,
    input  logic             out_ready,
    output logic             ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] cnt
);

    slot_st_e         st_q;
    slot_st_e         st_d;
    logic [W-1:0]     data_q;
    logic [W-1:0]     data_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             drain;

    always_comb begin
        drain  = (st_q == ST_FULL) && out_ready;
        st_d   = st_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        // A load wins over a drain: the slot refills in the same cycle.
        if (load) begin
            st_d   = ST_FULL;
            data_d = load_data;
        end else if (drain) begin
            st_d = ST_EMPTY;
        end
        if (drain) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_EMPTY;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            st_q   <= st_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ready     = (st_q == ST_EMPTY) || out_ready;
    assign out_valid = (st_q == ST_FULL);
    assign out_data  = data_q;
    assign cnt       = cnt_q;

endmodule

// File: rtl/demux3_stream.sv
// 1-to-3 valid/ready stream demultiplexer: decodes s1/s0 to a
// target channel and steers each accepted word into its slot.
module demux3_stream
    import demux3_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    demux3_stream_if.slave bus
);

    logic [NCH-1:0]   tgt;
    logic [NCH-1:0]   slot_rdy;
    logic [NCH-1:0]   load;
    logic [NCH-1:0]   slot_vld;
    logic [W-1:0]     slot_data [NCH];
    logic [CNT_W-1:0] slot_cnt  [NCH];
    logic             acc;

    always_comb begin
        tgt  = sel_decode(bus.s1, bus.s0);
        acc  = bus.in_valid && |(tgt & slot_rdy);
        load = acc ? tgt : '0;
    end

    // Ready depends only on the decoded target, so a stalled
    // channel never blocks words headed elsewhere.
    assign bus.in_ready  = |(tgt & slot_rdy);
    assign bus.out_valid = slot_vld;
    assign bus.out1_data = slot_data[0];
    assign bus.out2_data = slot_data[1];
    assign bus.out3_data = slot_data[2];
    assign bus.out1_cnt  = slot_cnt[0];
    assign bus.out2_cnt  = slot_cnt[1];
    assign bus.out3_cnt  = slot_cnt[2];

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux_slot #(
            .W(W)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[k]),
            .load_data(bus.in_data),
            .out_ready(bus.out_ready[k]),
            .ready    (slot_rdy[k]),
            .out_valid(slot_vld[k]),
            .out_data (slot_data[k]),
            .cnt      (slot_cnt[k])
        );
    end

endmodule
